jtag_tap_param: RTL and testbench

//  Parametrised IEEE 1149.1 TAP controller: 16-state TAP FSM, instruction register and built-in

---
 rtl/jtag_tap_param_if.sv | 31 +++
 rtl/jtag_tap_param.sv | 175 +++++++++++++++++
 tb/tb_jtag_tap_param.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_tap_param_if.sv
// Chain-side signal bundle of jtag_tap_param: state flags, selects and the serial data paths.
// master = TAP controller, slave = boundary-scan / user chains.
interface jtag_tap_param_if #(
  parameter int unsigned NUM_USER = 2
);
  logic                shift_dr_o;
  logic                pause_dr_o;
  logic                update_dr_o;
  logic                capture_dr_o;
  logic                extest_select_o;
  logic                sample_preload_select_o;
  logic [NUM_USER-1:0] user_select_o;
  logic                test_logic_reset_o;
  logic                tdo_o;
  logic                bs_chain_tdi_i;
  logic [NUM_USER-1:0] user_tdi_i;

  modport master (
    output shift_dr_o, pause_dr_o, update_dr_o, capture_dr_o,
    output extest_select_o, sample_preload_select_o, user_select_o,
    output test_logic_reset_o, tdo_o,
    input  bs_chain_tdi_i, user_tdi_i
  );

  modport slave (
    input  shift_dr_o, pause_dr_o, update_dr_o, capture_dr_o,
    input  extest_select_o, sample_preload_select_o, user_select_o,
    input  test_logic_reset_o, tdo_o,
    output bs_chain_tdi_i, user_tdi_i
  );
endinterface

// File: rtl/jtag_tap_param.sv
// Parametrised IEEE 1149.1 TAP: 16-state FSM, IR, BYPASS and optional IDCODE register.
// Optional IDCODE register enabled by defining JTAG_TAP_IDCODE_EN.
module jtag_tap_param #(
  parameter int unsigned IR_WIDTH     = 4,
  parameter int unsigned NUM_USER     = 2,
  parameter int unsigned USER_BASE    = 8,
  parameter logic [31:0] IDCODE_VALUE = 32'h149511C3
) (
  input  logic tck_pad_i,
  input  logic trst_pad_i,
  input  logic tms_pad_i,
  input  logic tdi_pad_i,
  output logic tdo_pad_o,
  output logic tdo_padoe_o,
  jtag_tap_param_if.master chain
);

  if (IR_WIDTH < 4 || NUM_USER < 1 || USER_BASE <= 2 ||
      USER_BASE + NUM_USER - 1 >= 2 ** IR_WIDTH - 1 || IDCODE_VALUE[0] != 1'b1)
  begin : gen_bad_params
    $error("jtag_tap_param: illegal parameter combination");
  end

  localparam logic [IR_WIDTH-1:0] OpExtest = '0;
  localparam logic [IR_WIDTH-1:0] OpSample = IR_WIDTH'(1);
`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] OpIdcode = IR_WIDTH'(2);
  localparam logic [IR_WIDTH-1:0] IrReset  = OpIdcode;
`else
  localparam logic [IR_WIDTH-1:0] IrReset  = '1;
`endif

  typedef enum logic [3:0] {
    StTlr, StRti,
    StSelDr, StCapDr, StShiftDr, StExit1Dr, StPauseDr, StExit2Dr, StUpdDr,
    StSelIr, StCapIr, StShiftIr, StExit1Ir, StPauseIr, StExit2Ir, StUpdIr
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge tck_pad_i or posedge trst_pad_i) begin
    if (trst_pad_i) state_q <= StTlr;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StTlr:     state_d = tms_pad_i ? StTlr     : StRti;
      StRti:     state_d = tms_pad_i ? StSelDr   : StRti;
      StSelDr:   state_d = tms_pad_i ? StSelIr   : StCapDr;
      StCapDr:   state_d = tms_pad_i ? StExit1Dr : StShiftDr;
      StShiftDr: state_d = tms_pad_i ? StExit1Dr : StShiftDr;
      StExit1Dr: state_d = tms_pad_i ? StUpdDr   : StPauseDr;
      StPauseDr: state_d = tms_pad_i ? StExit2Dr : StPauseDr;
      StExit2Dr: state_d = tms_pad_i ? StUpdDr   : StShiftDr;
      StUpdDr:   state_d = tms_pad_i ? StSelDr   : StRti;
      StSelIr:   state_d = tms_pad_i ? StTlr     : StCapIr;
      StCapIr:   state_d = tms_pad_i ? StExit1Ir : StShiftIr;
      StShiftIr: state_d = tms_pad_i ? StExit1Ir : StShiftIr;
      StExit1Ir: state_d = tms_pad_i ? StUpdIr   : StPauseIr;
      StPauseIr: state_d = tms_pad_i ? StExit2Ir : StPauseIr;
      StExit2Ir: state_d = tms_pad_i ? StUpdIr   : StShiftIr;
      StUpdIr:   state_d = tms_pad_i ? StSelDr   : StRti;
      default:   state_d = StTlr;
    endcase
  end

  logic shift_ir, shift_dr, capture_dr;
  assign shift_ir   = (state_q == StShiftIr);
  assign shift_dr   = (state_q == StShiftDr);
  assign capture_dr = (state_q == StCapDr);

  assign chain.shift_dr_o         = shift_dr;
  assign chain.pause_dr_o         = (state_q == StPauseDr);
  assign chain.update_dr_o        = (state_q == StUpdDr);
  assign chain.capture_dr_o       = capture_dr;
  assign chain.test_logic_reset_o = (state_q == StTlr);
  assign chain.tdo_o              = tdi_pad_i;

  // Instruction path: shift register plus active IR
  logic [IR_WIDTH-1:0] ir_shift_q, ir_q;

  always_ff @(posedge tck_pad_i or posedge trst_pad_i) begin
    if (trst_pad_i) begin
      ir_shift_q <= '0;
      ir_q       <= IrReset;
    end else begin
      if (state_q == StCapIr) ir_shift_q <= IR_WIDTH'(1);
      else if (shift_ir)      ir_shift_q <= {tdi_pad_i, ir_shift_q[IR_WIDTH-1:1]};
      // Entering Test-Logic-Reset by TMS reloads the same value as trst
      if (state_d == StTlr)         ir_q <= IrReset;
      else if (state_q == StUpdIr)  ir_q <= ir_shift_q;
    end
  end

  // Registered instruction decode
  logic                extest_q, sample_q;
  logic [NUM_USER-1:0] user_q, user_d;

  always_comb begin
    user_d = '0;
    for (int k = 0; k < NUM_USER; k++) begin
      user_d[k] = (ir_q == IR_WIDTH'(USER_BASE + k));
    end
  end

  always_ff @(posedge tck_pad_i or posedge trst_pad_i) begin
    if (trst_pad_i) begin
      extest_q <= 1'b0;
      sample_q <= 1'b0;
      user_q   <= '0;
    end else begin
      extest_q <= (ir_q == OpExtest);
      sample_q <= (ir_q == OpSample);
      user_q   <= user_d;
    end
  end

  assign chain.extest_select_o         = extest_q;
  assign chain.sample_preload_select_o = sample_q;
  assign chain.user_select_o           = user_q;

  logic bypass_q;
  always_ff @(posedge tck_pad_i or posedge trst_pad_i) begin
    if (trst_pad_i)      bypass_q <= 1'b0;
    else if (capture_dr) bypass_q <= 1'b0;
    else if (shift_dr)   bypass_q <= tdi_pad_i;
  end

`ifdef JTAG_TAP_IDCODE_EN
  logic        idcode_sel_q;
  logic [31:0] idcode_q;

  always_ff @(posedge tck_pad_i or posedge trst_pad_i) begin
    if (trst_pad_i) begin
      idcode_sel_q <= 1'b1;
      idcode_q     <= '0;
    end else begin
      idcode_sel_q <= (ir_q == OpIdcode);
      if (capture_dr)    idcode_q <= IDCODE_VALUE;
      else if (shift_dr) idcode_q <= {tdi_pad_i, idcode_q[31:1]};
    end
  end
`endif

  // Return-data mux; unknown opcodes fall through to the bypass bit
  logic tdo_mux;
  always_comb begin
    tdo_mux = bypass_q;
    if (shift_ir) begin
      tdo_mux = ir_shift_q[0];
    end else if (shift_dr) begin
      if (extest_q || sample_q) tdo_mux = chain.bs_chain_tdi_i;
`ifdef JTAG_TAP_IDCODE_EN
      if (idcode_sel_q) tdo_mux = idcode_q[0];
`endif
      for (int k = 0; k < NUM_USER; k++) begin
        if (user_q[k]) tdo_mux = chain.user_tdi_i[k];
      end
    end
  end

  // TDO changes on the falling edge; outside shift states it holds with OE low
  always_ff @(negedge tck_pad_i or posedge trst_pad_i) begin
    if (trst_pad_i) begin
      tdo_pad_o   <= 1'b0;
      tdo_padoe_o <= 1'b0;
    end else begin
      tdo_padoe_o <= shift_ir | shift_dr;
      if (shift_ir || shift_dr) tdo_pad_o <= tdo_mux;
    end
  end

endmodule

// File: tb/tb_jtag_tap_param.sv
// Directed self-checking bench for jtag_tap_param; expectations follow JTAG_TAP_IDCODE_EN.
module tb_jtag_tap_param;
  localparam logic [31:0] IdcodeValue = 32'h149511C3;

  logic tck = 1'b0;
  logic trst = 1'b1;
  logic tms = 1'b1;
  logic tdi = 1'b0;
  logic tdo, oe;
  int   checks = 0;
  int   errors = 0;

  always #5 tck = ~tck;

  jtag_tap_param_if #(.NUM_USER(2)) chain ();

  jtag_tap_param #(
    .IR_WIDTH(4), .NUM_USER(2), .USER_BASE(8), .IDCODE_VALUE(IdcodeValue)
  ) dut (
    .tck_pad_i(tck), .trst_pad_i(trst), .tms_pad_i(tms), .tdi_pad_i(tdi),
    .tdo_pad_o(tdo), .tdo_padoe_o(oe), .chain(chain)
  );

  // One TCK: drive at posedge+1, sample TDO/OE after the negedge, return at posedge+1.
  task automatic step(input logic s_tms, input logic s_tdi, output logic o_tdo,
                      output logic o_oe);
    tms = s_tms;
    tdi = s_tdi;
    @(negedge tck); #1;
    o_tdo = tdo;
    o_oe  = oe;
    @(posedge tck); #1;
  endtask

  task automatic goto_shift_dr();
    logic d0, d1;
    step(1'b1, 1'b0, d0, d1);
    step(1'b0, 1'b0, d0, d1);
    step(1'b0, 1'b0, d0, d1);
  endtask

  task automatic leave_dr();
    logic d0, d1;
    step(1'b1, 1'b0, d0, d1);
    step(1'b0, 1'b0, d0, d1);
  endtask

  task automatic load_ir(input logic [3:0] op);
    logic d0, d1;
    step(1'b1, 1'b0, d0, d1);
    step(1'b1, 1'b0, d0, d1);
    step(1'b0, 1'b0, d0, d1);
    step(1'b0, 1'b0, d0, d1);
    for (int i = 0; i < 4; i++) step(i == 3, op[i], d0, d1);
    step(1'b1, 1'b0, d0, d1);
    step(1'b0, 1'b0, d0, d1);
  endtask

  // Expected 32-bit TDO stream in the reset/IDCODE instruction
  function automatic logic [31:0] exp_dr32(input logic [31:0] pat);
`ifdef JTAG_TAP_IDCODE_EN
    exp_dr32 = IdcodeValue;
`else
    exp_dr32 = {pat[30:0], 1'b0};
`endif
  endfunction

  task automatic test_reset();
    logic [9:0] got;
    got = {chain.test_logic_reset_o, chain.shift_dr_o, chain.pause_dr_o, chain.update_dr_o,
           chain.capture_dr_o, chain.extest_select_o, chain.sample_preload_select_o,
           chain.user_select_o, oe};
    checks++;
    if (got !== 10'b1000000000) begin
      errors++; $display("FAIL reset_flags: got %b expected %b", got, 10'b1000000000);
    end
    checks++;
    if (tdo !== 1'b0) begin errors++; $display("FAIL reset_tdo: got %b expected 0", tdo); end
    tms = 1'b1;
    @(posedge tck); #1;
    trst = 1'b0;
    step(1'b0, 1'b0, got[0], got[1]);
  endtask

  task automatic test_idcode();
    logic [31:0] pat = 32'hDEADBEEF;
    logic [31:0] got;
    logic        o, e, oe_all;
    oe_all = 1'b1;
    step(1'b1, 1'b0, o, e);
    step(1'b0, 1'b0, o, e);
    checks++;
    if (chain.capture_dr_o !== 1'b1) begin
      errors++; $display("FAIL capture_flag: got %b expected 1", chain.capture_dr_o);
    end
    step(1'b0, 1'b0, o, e);
    checks++;
    if (chain.shift_dr_o !== 1'b1) begin
      errors++; $display("FAIL shift_flag: got %b expected 1", chain.shift_dr_o);
    end
    for (int i = 0; i < 16; i++) begin
      step(i == 15, pat[i], got[i], e);
      oe_all &= e;
    end
    step(1'b0, 1'b0, o, e);
    step(1'b0, 1'b0, o, e);
    checks++;
    if (chain.pause_dr_o !== 1'b1 || e !== 1'b0) begin
      errors++; $display("FAIL pause_dr: got pause=%b oe=%b expected pause=1 oe=0",
                         chain.pause_dr_o, e);
    end
    step(1'b1, 1'b0, o, e);
    step(1'b0, 1'b0, o, e);
    for (int i = 16; i < 32; i++) begin
      step(i == 31, pat[i], got[i], e);
      oe_all &= e;
    end
    checks++;
    if (got !== exp_dr32(pat)) begin
      errors++; $display("FAIL idcode_shift: got %h expected %h", got, exp_dr32(pat));
    end
    checks++;
    if (oe_all !== 1'b1) begin errors++; $display("FAIL idcode_oe: got %b expected 1", oe_all); end
    step(1'b1, 1'b0, o, e);
    checks++;
    if (chain.update_dr_o !== 1'b1) begin
      errors++; $display("FAIL update_flag: got %b expected 1", chain.update_dr_o);
    end
    step(1'b0, 1'b0, o, e);
  endtask

  task automatic test_trst_mid_shift();
    logic       o, e;
    logic [9:0] got;
    goto_shift_dr();
    step(1'b0, 1'b1, o, e);
    step(1'b0, 1'b1, o, e);
    #2 trst = 1'b1;
    #1;
    got = {chain.test_logic_reset_o, chain.shift_dr_o, chain.pause_dr_o, chain.update_dr_o,
           chain.capture_dr_o, chain.extest_select_o, chain.sample_preload_select_o,
           chain.user_select_o, oe};
    checks++;
    if (got !== 10'b1000000000 || tdo !== 1'b0) begin
      errors++; $display("FAIL trst_abort: got flags=%b tdo=%b expected flags=%b tdo=0",
                         got, tdo, 10'b1000000000);
    end
    tms = 1'b1;
    @(posedge tck); #1;
    trst = 1'b0;
    step(1'b0, 1'b0, o, e);
  endtask

  task automatic test_tms_reset();
    logic        o, e;
    logic [31:0] pat = 32'h0F0F1234;
    logic [31:0] got;
    load_ir(4'h9);
    step(1'b1, 1'b0, o, e);
    step(1'b1, 1'b0, o, e);
    step(1'b0, 1'b0, o, e);
    step(1'b0, 1'b0, o, e);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, o, e);
    checks++;
    if (chain.test_logic_reset_o !== 1'b1) begin
      errors++; $display("FAIL tms_reset_tlr: got %b expected 1", chain.test_logic_reset_o);
    end
    step(1'b0, 1'b0, o, e);
    checks++;
    if (chain.user_select_o !== 2'b00) begin
      errors++; $display("FAIL tms_reset_user: got %b expected 00", chain.user_select_o);
    end
    goto_shift_dr();
    for (int i = 0; i < 32; i++) step(i == 31, pat[i], got[i], e);
    checks++;
    if (got !== exp_dr32(pat)) begin
      errors++; $display("FAIL tms_reset_ir: got %h expected %h", got, exp_dr32(pat));
    end
    leave_dr();
  endtask

  task automatic test_bypass();
    logic [7:0] pat = 8'hA5;
    logic [8:0] got;
    logic       e, oe_all;
    oe_all = 1'b1;
    load_ir(4'hF);
    goto_shift_dr();
    for (int i = 0; i < 9; i++) begin
      step(i == 8, (i < 8) ? pat[i] : 1'b0, got[i], e);
      oe_all &= e;
    end
    checks++;
    if (got !== {pat, 1'b0}) begin
      errors++; $display("FAIL bypass_a5: got %h expected %h", got, {pat, 1'b0});
    end
    checks++;
    if (oe_all !== 1'b1) begin errors++; $display("FAIL bypass_oe: got %b expected 1", oe_all); end
    step(1'b1, 1'b0, got[0], e);
    checks++;
    if (e !== 1'b0 || got[0] !== 1'b1) begin
      errors++; $display("FAIL bypass_exit_hold: got oe=%b tdo=%b expected oe=0 tdo=1",
                         e, got[0]);
    end
    step(1'b0, 1'b0, got[0], e);
  endtask

  task automatic test_user();
    logic [3:0] op = 4'h9;
    logic [3:0] irout;
    logic [7:0] pat = 8'h3C;
    logic [7:0] got;
    logic [3:0] bpat = 4'b1011;
    logic [4:0] bgot;
    logic       o, e;
    step(1'b1, 1'b0, o, e);
    step(1'b1, 1'b0, o, e);
    step(1'b0, 1'b0, o, e);
    step(1'b0, 1'b0, o, e);
    for (int i = 0; i < 4; i++) step(i == 3, op[i], irout[i], e);
    checks++;
    if (irout !== 4'b0001) begin
      errors++; $display("FAIL ir_capture_out: got %b expected 0001", irout);
    end
    step(1'b1, 1'b0, o, e);
    step(1'b0, 1'b0, o, e);
    goto_shift_dr();
    checks++;
    if (chain.user_select_o !== 2'b10) begin
      errors++; $display("FAIL user_select: got %b expected 10", chain.user_select_o);
    end
    for (int i = 0; i < 8; i++) begin
      chain.user_tdi_i = {pat[i], ~pat[i]};
      step(i == 7, 1'b0, got[i], e);
    end
    checks++;
    if (got !== pat) begin errors++; $display("FAIL user1_tdo: got %h expected %h", got, pat); end
    leave_dr();
    load_ir(4'h5);
    goto_shift_dr();
    checks++;
    if (chain.user_select_o !== 2'b00) begin
      errors++; $display("FAIL op5_select: got %b expected 00", chain.user_select_o);
    end
    chain.user_tdi_i = 2'b11;
    for (int i = 0; i < 5; i++) step(i == 4, (i < 4) ? bpat[i] : 1'b0, bgot[i], e);
    checks++;
    if (bgot !== {bpat, 1'b0}) begin
      errors++; $display("FAIL op5_bypass: got %b expected %b", bgot, {bpat, 1'b0});
    end
    leave_dr();
  endtask

  task automatic test_boundary_scan();
    logic [3:0] op;
    logic [1:0] sel;
    logic [5:0] pat = 6'b101100;
    logic [5:0] got;
    logic       e;
    for (int k = 0; k < 2; k++) begin
      op = 4'(k);
      load_ir(op);
      goto_shift_dr();
      sel = {chain.extest_select_o, chain.sample_preload_select_o};
      checks++;
      if (sel !== ((k == 0) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL bs_select op%0d: got %b expected %b", k, sel,
                           (k == 0) ? 2'b10 : 2'b01);
      end
      for (int i = 0; i < 6; i++) begin
        chain.bs_chain_tdi_i = pat[i];
        step(i == 5, 1'b0, got[i], e);
      end
      checks++;
      if (got !== pat) begin
        errors++; $display("FAIL bs_tdo op%0d: got %b expected %b", k, got, pat);
      end
      leave_dr();
    end
  endtask

  task automatic test_opcode2();
    logic [7:0] got;
    logic [7:0] exp;
    logic       e;
`ifdef JTAG_TAP_IDCODE_EN
    exp = IdcodeValue[7:0];
`else
    exp = 8'hFE;
`endif
    load_ir(4'h2);
    goto_shift_dr();
    for (int i = 0; i < 8; i++) step(i == 7, 1'b1, got[i], e);
    checks++;
    if (got !== exp) begin errors++; $display("FAIL opcode2: got %h expected %h", got, exp); end
    checks++;
    if (chain.tdo_o !== tdi) begin
      errors++; $display("FAIL tdo_passthru: got %b expected %b", chain.tdo_o, tdi);
    end
    leave_dr();
  endtask

  initial begin
    chain.bs_chain_tdi_i = 1'b0;
    chain.user_tdi_i     = 2'b00;
    #2;
    test_reset();
    test_idcode();
    test_trst_mid_shift();
    test_tms_reset();
    test_bypass();
    test_user();
    test_boundary_scan();
    test_opcode2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end
endmodule
